// File: rtl/video_timing_checker.sv
// Sink-side video timing monitor: measures line/frame timing from vsync/hsync/de,
// regenerates pixel coordinates, checks against the expected format and tracks lock.
module video_timing_checker #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        de_in,
  input  logic        clr_err_in,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        pix_valid_out,
  output logic [11:0] h_total_out,
  output logic [11:0] h_active_out,
  output logic [10:0] v_total_out,
  output logic [10:0] v_active_out,
  output logic        meas_valid_out,
  output logic        locked_out,
  output logic [3:0]  err_flags_out
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam logic [11:0] H_TOTAL_C    = 12'(H_TOTAL);
  localparam logic [11:0] H_ACTIVE_C   = 12'(H_ACTIVE);
  localparam logic [10:0] V_TOTAL_C    = 11'(V_TOTAL);
  localparam logic [10:0] V_ACTIVE_C   = 11'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N_C     = 4'(LOCK_FRAMES);
  localparam logic [11:0] LOSS_LIMIT_C = 12'hFFF;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    sat_inc12 = (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    sat_inc11 = (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    sat_inc10 = (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic        vs1_r, hs1_r, de1_r;
  logic        vs2_r, hs2_r, de2_r;
  logic [11:0] hcnt_r, dcnt_r;
  logic [10:0] lines_r, act_lines_r;
  logic [1:0]  line_err_r;
  logic        first_line_r, first_frame_r;
  logic [9:0]  x_r, y_r;
  lock_state_t state_r, state_n;
  logic [3:0]  good_cnt_r, good_cnt_n;

  logic        v_edge_s, h_edge_s, de_fall_s, loss_s;
  logic [11:0] h_len_s, d_len_s;
  logic        line_chk_s, h_tot_bad_s, h_act_bad_s;
  logic [10:0] lines_now_s, act_now_s;
  logic [1:0]  frame_line_err_s;
  logic        frame_chk_s, v_tot_bad_s, v_act_bad_s, frame_good_s;
  logic [3:0]  new_err_s;

  assign v_edge_s  = vs1_r & ~vs2_r;
  assign h_edge_s  = hs1_r & ~hs2_r;
  assign de_fall_s = ~de1_r & de2_r;
  assign loss_s    = ~h_edge_s & (hcnt_r == LOSS_LIMIT_C);

  // A line spans the clocks after one hsync edge up to and including the next.
  assign h_len_s     = sat_inc12(hcnt_r);
  assign d_len_s     = de1_r ? sat_inc12(dcnt_r) : dcnt_r;
  assign line_chk_s  = h_edge_s & ~first_line_r;
  assign h_tot_bad_s = line_chk_s & (h_len_s != H_TOTAL_C);
  assign h_act_bad_s = line_chk_s & (d_len_s != 12'd0) & (d_len_s != H_ACTIVE_C);

  assign lines_now_s = h_edge_s ? sat_inc11(lines_r) : lines_r;
  assign act_now_s   = (h_edge_s && (d_len_s != 12'd0)) ? sat_inc11(act_lines_r) : act_lines_r;

  assign frame_line_err_s = line_err_r | {h_act_bad_s, h_tot_bad_s};
  assign frame_chk_s      = v_edge_s & ~first_frame_r;
  assign v_tot_bad_s      = frame_chk_s & (lines_now_s != V_TOTAL_C);
  assign v_act_bad_s      = frame_chk_s & (act_now_s != V_ACTIVE_C);
  assign frame_good_s     = frame_chk_s & ~(|{v_act_bad_s, v_tot_bad_s, frame_line_err_s});
  assign new_err_s        = v_edge_s ? {v_act_bad_s, v_tot_bad_s, frame_line_err_s} : 4'b0000;

  // Input capture with syncs normalised to active-high, plus a delay stage for edges
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vs1_r <= 1'b0;
      hs1_r <= 1'b0;
      de1_r <= 1'b0;
      vs2_r <= 1'b0;
      hs2_r <= 1'b0;
      de2_r <= 1'b0;
    end else begin
      vs1_r <= SYNC_POL ? vsync_in : ~vsync_in;
      hs1_r <= SYNC_POL ? hsync_in : ~hsync_in;
      de1_r <= de_in;
      vs2_r <= vs1_r;
      hs2_r <= hs1_r;
      de2_r <= de1_r;
    end
  end

  // Line and frame counters; loss of sync re-arms the first-line/frame exemptions
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcnt_r        <= 12'd0;
      dcnt_r        <= 12'd0;
      lines_r       <= 11'd0;
      act_lines_r   <= 11'd0;
      line_err_r    <= 2'b00;
      first_line_r  <= 1'b1;
      first_frame_r <= 1'b1;
    end else begin
      hcnt_r <= h_edge_s ? 12'd0 : sat_inc12(hcnt_r);
      dcnt_r <= h_edge_s ? 12'd0 : d_len_s;
      if (v_edge_s) begin
        lines_r     <= 11'd0;
        act_lines_r <= 11'd0;
      end else begin
        lines_r     <= lines_now_s;
        act_lines_r <= act_now_s;
      end
      if (loss_s || v_edge_s) begin
        line_err_r <= 2'b00;
      end else begin
        line_err_r <= frame_line_err_s;
      end
      if (loss_s) begin
        first_line_r  <= 1'b1;
        first_frame_r <= 1'b1;
      end else begin
        if (h_edge_s) first_line_r <= 1'b0;
        if (v_edge_s) first_frame_r <= 1'b0;
      end
    end
  end

  // Pixel coordinates, presented alongside the de that produced them
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      x_out         <= 10'd0;
      y_out         <= 10'd0;
      pix_valid_out <= 1'b0;
    end else begin
      if (de1_r) begin
        x_r <= sat_inc10(x_r);
      end else if (de_fall_s) begin
        x_r <= 10'd0;
      end
      if (v_edge_s) begin
        y_r <= 10'd0;
      end else if (de_fall_s) begin
        y_r <= sat_inc10(y_r);
      end
      pix_valid_out <= de1_r;
      x_out         <= de1_r ? x_r : 10'd0;
      y_out         <= de1_r ? y_r : 10'd0;
    end
  end

  // Lock state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= UNLOCKED;
      good_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_n;
      good_cnt_r <= good_cnt_n;
    end
  end

  // Lock transitions, taken only at checked frame closes or on loss of sync
  always_comb begin
    state_n    = state_r;
    good_cnt_n = good_cnt_r;
    if (loss_s) begin
      state_n    = UNLOCKED;
      good_cnt_n = 4'd0;
    end else if (frame_chk_s) begin
      case (state_r)
        UNLOCKED: begin
          if (frame_good_s) begin
            good_cnt_n = 4'd1;
            state_n    = (LOCK_N_C <= 4'd1) ? LOCKED : ACQUIRE;
          end else begin
            good_cnt_n = 4'd0;
          end
        end
        ACQUIRE: begin
          if (frame_good_s) begin
            good_cnt_n = good_cnt_r + 4'd1;
            state_n    = ((good_cnt_r + 4'd1) >= LOCK_N_C) ? LOCKED : ACQUIRE;
          end else begin
            good_cnt_n = 4'd0;
            state_n    = UNLOCKED;
          end
        end
        LOCKED: begin
          if (frame_good_s) begin
            state_n = LOCKED;
          end else begin
            good_cnt_n = 4'd0;
            state_n    = UNLOCKED;
          end
        end
        default: begin
          good_cnt_n = 4'd0;
          state_n    = UNLOCKED;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Measurement, lock and sticky error outputs; a new error beats a same-clock clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_total_out    <= 12'd0;
      h_active_out   <= 12'd0;
      v_total_out    <= 11'd0;
      v_active_out   <= 11'd0;
      meas_valid_out <= 1'b0;
      locked_out     <= 1'b0;
      err_flags_out  <= 4'b0000;
    end else begin
      if (h_edge_s) begin
        h_total_out  <= h_len_s;
        h_active_out <= d_len_s;
      end
      if (v_edge_s) begin
        v_total_out  <= lines_now_s;
        v_active_out <= act_now_s;
      end
      meas_valid_out <= v_edge_s;
      locked_out     <= (state_n == LOCKED);
      err_flags_out  <= (clr_err_in ? 4'b0000 : err_flags_out) | new_err_s;
    end
  end

endmodule
